// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and helpers for the forwarding/hazard unit: scoreboard
// state encoding and a constant clog2 used to size selects and counters.
package fwd_hazard_unit_pkg;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

    // Ceiling log2 with a floor of 1 so a single-value field still gets a bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_select.sv
// Priority encoder for one ALU operand: picks the youngest write-back stage
// whose non-zero destination matches the source register.
module fwd_select #(
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 3,
    parameter int SEL_W   = 2
) (
    input  logic [REG_AW-1:0]         src_i,
    input  logic [NUM_FWD-1:0]        reg_write_i,
    input  logic [NUM_FWD*REG_AW-1:0] rd_i,
    output logic [SEL_W-1:0]          sel_o
);

    // Walk oldest to youngest so the lowest matching index wins.
    always_comb begin
        sel_o = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (reg_write_i[k] && (rd_i[k*REG_AW +: REG_AW] != '0) &&
                (rd_i[k*REG_AW +: REG_AW] == src_i))
                sel_o = SEL_W'(k + 1);
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use / multiply hazard detection, a one-entry
// multiply scoreboard and a saturating stall-cycle counter.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 3,
    parameter int SEL_W   = clog2(NUM_FWD + 1),
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_AW-1:0]         id_rs,
    input  logic [REG_AW-1:0]         id_rt,
    input  logic                      id_uses_rt,
    input  logic                      id_is_mul,
    input  logic                      flush,
    input  logic [REG_AW-1:0]         ex_rs,
    input  logic [REG_AW-1:0]         ex_rt,
    input  logic                      ex_mem_read,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic [NUM_FWD-1:0]        fwd_reg_write,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
    input  logic                      mul_issue,
    input  logic [REG_AW-1:0]         mul_rd,
    input  logic                      clr_cnt,
    output logic [SEL_W-1:0]          forward_a,
    output logic [SEL_W-1:0]          forward_b,
    output logic                      stall,
    output logic                      bubble,
    output logic                      mul_busy,
    output logic                      mul_err,
    output logic [CNT_W-1:0]          stall_cycles
);

    localparam int CW = clog2(MUL_LAT + 1);

    mul_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    fwd_select #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_fwd_a (
        .src_i       (ex_rs),
        .reg_write_i (fwd_reg_write),
        .rd_i        (fwd_rd),
        .sel_o       (forward_a)
    );

    fwd_select #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_fwd_b (
        .src_i       (ex_rt),
        .reg_write_i (fwd_reg_write),
        .rd_i        (fwd_rd),
        .sel_o       (forward_b)
    );

    logic lu, md, ms, match_issue, match_pend;

    assign lu = ex_mem_read && (ex_rd != '0) &&
                ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign match_issue = (mul_rd != '0) &&
                         ((mul_rd == id_rs) || (id_uses_rt && (mul_rd == id_rt)));
    assign match_pend  = (pend_rd_q != '0) &&
                         ((pend_rd_q == id_rs) || (id_uses_rt && (pend_rd_q == id_rt)));
    assign md = (mul_issue && match_issue) || (mul_busy && match_pend);
    assign ms = id_is_mul && (mul_busy || mul_issue);

    assign stall        = (lu || md || ms) && !flush;
    assign bubble       = stall || flush;
    assign mul_err      = err_q;
    assign stall_cycles = stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= MUL_IDLE;
            cnt_q       <= '0;
            pend_rd_q   <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_rd_q   <= pend_rd_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A second issue while busy is a protocol violation: flag it, keep tracking the first.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_rd_d = pend_rd_q;
        err_d     = err_q;
        case (state_q)
            MUL_IDLE: begin
                if (mul_issue) begin
                    state_d   = MUL_BUSY;
                    cnt_d     = CW'(MUL_LAT);
                    pend_rd_d = mul_rd;
                end
            end
            MUL_BUSY: begin
                if (mul_issue) err_d = 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = MUL_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_comb begin
        mul_busy = (state_q == MUL_BUSY);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_cnt)
            stall_cnt_d = '0;
        else if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding priority, load-use, multiply
// scoreboard timing/error, async reset and counter saturation/clear.
module tb_fwd_hazard_unit;

    localparam int REG_AW  = 5;
    localparam int NUM_FWD = 3;
    localparam int SEL_W   = 2;
    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [REG_AW-1:0]         id_rs, id_rt, ex_rs, ex_rt, ex_rd, mul_rd;
    logic                      id_uses_rt, id_is_mul, flush, ex_mem_read, mul_issue, clr_cnt;
    logic [NUM_FWD-1:0]        fwd_reg_write;
    logic [NUM_FWD*REG_AW-1:0] fwd_rd;
    logic [SEL_W-1:0]          forward_a, forward_b;
    logic                      stall, bubble, mul_busy, mul_err;
    logic [CNT_W-1:0]          stall_cycles;

    int checks = 0;
    int errors = 0;

    fwd_hazard_unit #(
        .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W),
        .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_is_mul(id_is_mul),
        .flush(flush), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .fwd_reg_write(fwd_reg_write), .fwd_rd(fwd_rd),
        .mul_issue(mul_issue), .mul_rd(mul_rd), .clr_cnt(clr_cnt),
        .forward_a(forward_a), .forward_b(forward_b), .stall(stall), .bubble(bubble),
        .mul_busy(mul_busy), .mul_err(mul_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_is_mul = 1'b0; flush = 1'b0;
        ex_rs = '0; ex_rt = '0; ex_mem_read = 1'b0; ex_rd = '0;
        fwd_reg_write = '0; fwd_rd = '0; mul_issue = 1'b0; mul_rd = '0; clr_cnt = 1'b0;
        #2;
        chk("rst_busy", 32'(mul_busy), 0);
        chk("rst_err", 32'(mul_err), 0);
        chk("rst_cnt", 32'(stall_cycles), 0);
        chk("rst_stall", 32'(stall), 0);
        tick();
        reset = 1'b0;
        tick();

        // Forwarding priority
        fwd_reg_write = 3'b011; fwd_rd = {5'd0, 5'd8, 5'd8}; ex_rs = 5'd8; #1;
        chk("fwd_a_s0", 32'(forward_a), 1);
        fwd_reg_write = 3'b010; #1;
        chk("fwd_a_s1", 32'(forward_a), 2);
        fwd_reg_write = 3'b100; fwd_rd = {5'd8, 5'd0, 5'd0}; ex_rs = 5'd0; ex_rt = 5'd8; #1;
        chk("fwd_b_s2", 32'(forward_b), 3);
        chk("fwd_a_none", 32'(forward_a), 0);
        fwd_reg_write = 3'b111; fwd_rd = '0; ex_rs = '0; ex_rt = '0; #1;
        chk("fwd_a_r0", 32'(forward_a), 0);
        chk("fwd_b_r0", 32'(forward_b), 0);
        fwd_reg_write = '0;

        // Load-use
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; #1;
        chk("lu_stall", 32'(stall), 1);
        chk("lu_bubble", 32'(bubble), 1);
        id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0; #1;
        chk("lu_no_rt", 32'(stall), 0);
        id_uses_rt = 1'b1; #1;
        chk("lu_rt", 32'(stall), 1);
        flush = 1'b1; #1;
        chk("lu_flush_stall", 32'(stall), 0);
        chk("lu_flush_bubble", 32'(bubble), 1);
        flush = 1'b0; ex_mem_read = 1'b0; ex_rd = '0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        chk("clr_cnt", 32'(stall_cycles), 0);

        // Multiply dependence stall timing
        mul_issue = 1'b1; mul_rd = 5'd12; id_rs = 5'd12; #1;
        chk("mul_c0_stall", 32'(stall), 1);
        chk("mul_c0_busy", 32'(mul_busy), 0);
        tick(); mul_issue = 1'b0; #1;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("mul_c%0d_stall", c), 32'(stall), 1);
            chk($sformatf("mul_c%0d_busy", c), 32'(mul_busy), 1);
            if (c == 2) begin
                id_is_mul = 1'b1; id_rs = 5'd0; #1;
                chk("mul_struct", 32'(stall), 1);
                id_is_mul = 1'b0; id_rs = 5'd12; #1;
            end
            tick();
        end
        chk("mul_c5_stall", 32'(stall), 0);
        chk("mul_c5_busy", 32'(mul_busy), 0);
        chk("mul_cnt5", 32'(stall_cycles), 5);
        id_rs = '0;

        // Double issue error; pend_rd and countdown stay with the first issue
        mul_issue = 1'b1; mul_rd = 5'd12; tick();      // now cycle 1
        mul_issue = 1'b0; tick();                      // cycle 2
        mul_issue = 1'b1; mul_rd = 5'd5; tick();       // cycle 3
        mul_issue = 1'b0;
        chk("err_set", 32'(mul_err), 1);
        id_rs = 5'd5; #1;
        chk("err_pend_old", 32'(stall), 0);
        id_rs = 5'd12; #1;
        chk("err_pend_keep", 32'(stall), 1);
        id_rs = '0;
        tick();                                        // cycle 4
        chk("err_c4_busy", 32'(mul_busy), 1);
        tick();                                        // cycle 5
        chk("err_c5_busy", 32'(mul_busy), 0);
        chk("err_sticky", 32'(mul_err), 1);

        // Async reset mid-multiply
        mul_issue = 1'b1; mul_rd = 5'd7; id_rs = 5'd7; tick();
        mul_issue = 1'b0; tick(); tick();              // cycle 3
        chk("pre_rst_busy", 32'(mul_busy), 1);
        #1 reset = 1'b1; #1;
        chk("arst_busy", 32'(mul_busy), 0);
        chk("arst_err", 32'(mul_err), 0);
        chk("arst_cnt", 32'(stall_cycles), 0);
        tick(); reset = 1'b0; id_rs = '0; tick();
        chk("post_rst_busy", 32'(mul_busy), 0);

        // Counter saturation and clear priority
        ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt", 32'(stall_cycles), 15);
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        chk("clr_over_stall", 32'(stall_cycles), 0);
        tick();
        chk("cnt_resume", 32'(stall_cycles), 1);
        ex_mem_read = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
